// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables combinationally and traps data-memory timeouts in ERR.
module multi_cycle_ctrl #(
    parameter int unsigned DM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic        cmp_eq,
    input  logic        dm_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  npc_sel,
    output logic        grf_we,
    output logic        dm_req,
    output logic        dm_we,
    output logic [2:0]  state,
    output logic [31:0] instr_cnt,
    output logic        err
);

    localparam int unsigned WAIT_W = (DM_TIMEOUT < 2) ? 1 : $clog2(DM_TIMEOUT + 1);
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NOP   = 4'd0,
        C_RTYPE = 4'd1,
        C_JR    = 4'd2,
        C_ORI   = 4'd3,
        C_LUI   = 4'd4,
        C_LW    = 4'd5,
        C_SW    = 4'd6,
        C_BEQ   = 4'd7,
        C_JAL   = 4'd8
    } iclass_t;

    state_t              r_state;
    state_t              w_state_next;
    iclass_t             w_class;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_inc;
    logic                w_wait_clr;
    logic                w_wait_step;
    logic                w_retire;
    logic [CNT_W-1:0]    r_instr_cnt;
    logic                r_err;

    // Instruction class decode from the IR opcode/func fields
    always_comb begin
        w_class = C_NOP;
        case (opcode)
            6'b000000: begin
                if (func == 6'b100001 || func == 6'b100011) begin
                    w_class = C_RTYPE;
                end else if (func == 6'b001000) begin
                    w_class = C_JR;
                end
            end
            6'b001101: w_class = C_ORI;
            6'b001111: w_class = C_LUI;
            6'b100011: w_class = C_LW;
            6'b101011: w_class = C_SW;
            6'b000100: w_class = C_BEQ;
            6'b000011: w_class = C_JAL;
            default:   w_class = C_NOP;
        endcase
    end

    assign w_wait_inc = r_wait_cnt + WAIT_W'(1);

    // Next-state and enable logic
    always_comb begin
        w_state_next = r_state;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        npc_sel      = 2'd0;
        grf_we       = 1'b0;
        dm_req       = 1'b0;
        dm_we        = 1'b0;
        w_retire     = 1'b0;
        w_wait_clr   = 1'b0;
        w_wait_step  = 1'b0;

        case (r_state)
            S_FETCH: begin
                ir_we        = 1'b1;
                pc_we        = 1'b1;
                npc_sel      = 2'd0;
                w_state_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_class == C_NOP) begin
                    w_retire     = 1'b1;
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (w_class)
                    C_RTYPE, C_ORI, C_LUI, C_JAL: w_state_next = S_WB;
                    C_LW, C_SW: begin
                        w_wait_clr   = 1'b1;
                        w_state_next = S_MEM;
                    end
                    C_BEQ: begin
                        pc_we        = cmp_eq;
                        npc_sel      = cmp_eq ? 2'd1 : 2'd0;
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end
                    C_JR: begin
                        pc_we        = 1'b1;
                        npc_sel      = 2'd3;
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end
                    default: w_state_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                dm_req = 1'b1;
                dm_we  = (w_class == C_SW);
                // A ready strobe on the timeout cycle still wins over ERR
                if (dm_ready) begin
                    if (w_class == C_LW) begin
                        w_state_next = S_WB;
                    end else begin
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end else begin
                    w_wait_step = 1'b1;
                    if (w_wait_inc == WAIT_W'(DM_TIMEOUT)) begin
                        w_state_next = S_ERR;
                    end
                end
            end
            S_WB: begin
                grf_we = 1'b1;
                if (w_class == C_JAL) begin
                    pc_we   = 1'b1;
                    npc_sel = 2'd2;
                end
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_ERR: w_state_next = S_ERR;
            default: w_state_next = S_ERR;
        endcase

        // Enables are held off for as long as reset is asserted
        if (!reset) begin
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            npc_sel = 2'd0;
            grf_we  = 1'b0;
            dm_req  = 1'b0;
            dm_we   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Wait counter, retire counter and sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt  <= '0;
            r_instr_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_wait_clr) begin
                r_wait_cnt <= '0;
            end else if (w_wait_step) begin
                r_wait_cnt <= w_wait_inc;
            end
            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
            if (w_state_next == S_ERR) begin
                r_err <= 1'b1;
            end
        end
    end

    assign state     = r_state;
    assign instr_cnt = r_instr_cnt;
    assign err       = r_err;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed self-checking bench for multi_cycle_ctrl: per-instruction vector
// table plus hand sequences for memory waits, timeout, ERR and async reset.
module tb_multi_cycle_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        cmp_eq;
    logic        dm_ready;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  npc_sel;
    logic        grf_we;
    logic        dm_req;
    logic        dm_we;
    logic [2:0]  state;
    logic [31:0] instr_cnt;
    logic        err;

    multi_cycle_ctrl #(.DM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func),
        .cmp_eq(cmp_eq), .dm_ready(dm_ready), .ir_we(ir_we), .pc_we(pc_we),
        .npc_sel(npc_sel), .grf_we(grf_we), .dm_req(dm_req), .dm_we(dm_we),
        .state(state), .instr_cnt(instr_cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       cmp;
        int         cyc;
        int         grf;
        int         pcw;
        int         dmr;
        int         dmw;
        logic [1:0] npc;
    } vec_t;

    vec_t vecs[12];

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    // Per-run observations
    int         r_cycles, r_grf, r_pcw, r_dmr, r_dmw, r_mem, r_saw_err;
    logic [1:0] r_npc;
    logic [2:0] trace [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one instruction from FETCH until it retires or ERR is entered.
    // ready_after = number of dm_ready=0 MEM cycles; negative means never ready.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic cmp, input int ready_after);
        logic [31:0] start;
        bit done;
        start = instr_cnt;
        opcode = op; func = fn; cmp_eq = cmp;
        r_cycles = 0; r_grf = 0; r_pcw = 0; r_dmr = 0; r_dmw = 0;
        r_mem = 0; r_saw_err = 0; r_npc = 2'd0; done = 0;
        while (!done && r_cycles < 64) begin
            @(negedge clk);
            if (state == 3'd3) begin
                r_mem++;
                dm_ready = (ready_after >= 0) && (r_mem > ready_after);
            end else begin
                dm_ready = 1'b1;
            end
            #1;
            trace[r_cycles] = state;
            r_cycles++;
            r_grf += int'(grf_we);
            r_pcw += int'(pc_we);
            r_dmr += int'(dm_req);
            r_dmw += int'(dm_we);
            if (pc_we) r_npc = r_npc | npc_sel;
            @(posedge clk);
            #1;
            if (instr_cnt != start) done = 1;
            if (state == 3'd7) begin
                r_saw_err = 1;
                done = 1;
            end
        end
        if (!done) check("run_bound", 32'(r_cycles), 32'd0);
    endtask

    initial begin
        //            name      op        fn        cmp  cyc grf pcw dmr dmw npc
        vecs[0]  = '{"addu",   6'h00, 6'h21, 1'b0, 4, 1, 1, 0, 0, 2'd0};
        vecs[1]  = '{"subu",   6'h00, 6'h23, 1'b0, 4, 1, 1, 0, 0, 2'd0};
        vecs[2]  = '{"jr",     6'h00, 6'h08, 1'b0, 3, 0, 2, 0, 0, 2'd3};
        vecs[3]  = '{"ori",    6'h0D, 6'h00, 1'b0, 4, 1, 1, 0, 0, 2'd0};
        vecs[4]  = '{"lui",    6'h0F, 6'h00, 1'b0, 4, 1, 1, 0, 0, 2'd0};
        vecs[5]  = '{"lw",     6'h23, 6'h00, 1'b0, 5, 1, 1, 1, 0, 2'd0};
        vecs[6]  = '{"sw",     6'h2B, 6'h00, 1'b0, 4, 0, 1, 1, 1, 2'd0};
        vecs[7]  = '{"beq_t",  6'h04, 6'h00, 1'b1, 3, 0, 2, 0, 0, 2'd1};
        vecs[8]  = '{"beq_nt", 6'h04, 6'h00, 1'b0, 3, 0, 1, 0, 0, 2'd0};
        vecs[9]  = '{"jal",    6'h03, 6'h00, 1'b0, 4, 1, 2, 0, 0, 2'd2};
        vecs[10] = '{"op3f",   6'h3F, 6'h00, 1'b0, 2, 0, 1, 0, 0, 2'd0};
        vecs[11] = '{"sll",    6'h00, 6'h00, 1'b0, 2, 0, 1, 0, 0, 2'd0};

        reset = 1'b0; opcode = '0; func = '0; cmp_eq = 1'b0; dm_ready = 1'b0;
        #3;
        check("rst_state", 32'(state), 32'd0);
        check("rst_en", {26'd0, ir_we, pc_we, grf_we, dm_req, dm_we, err}, 32'd0);
        check("rst_cnt", instr_cnt, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // addu: state walk 0,1,2,4 then back to 0, grf_we only in WB
        run_instr(6'h00, 6'h21, 1'b0, 0);
        exp_cnt++;
        check("addu_trace", {20'd0, trace[0], trace[1], trace[2], trace[3]},
              {20'd0, 3'd0, 3'd1, 3'd2, 3'd4});
        check("addu_end_state", 32'(state), 32'd0);
        check("addu_cnt", instr_cnt, 32'(exp_cnt));

        for (int i = 0; i < 12; i++) begin
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].cmp, 0);
            exp_cnt++;
            check({vecs[i].name, "_cycles"}, 32'(r_cycles), 32'(vecs[i].cyc));
            check({vecs[i].name, "_grf"}, 32'(r_grf), 32'(vecs[i].grf));
            check({vecs[i].name, "_pcwe"}, 32'(r_pcw), 32'(vecs[i].pcw));
            check({vecs[i].name, "_dmreq"}, 32'(r_dmr), 32'(vecs[i].dmr));
            check({vecs[i].name, "_dmwe"}, 32'(r_dmw), 32'(vecs[i].dmw));
            check({vecs[i].name, "_npc"}, 32'(r_npc), 32'(vecs[i].npc));
            check({vecs[i].name, "_cnt"}, instr_cnt, 32'(exp_cnt));
        end

        // lw with three wait cycles
        run_instr(6'h23, 6'h00, 1'b0, 3);
        exp_cnt++;
        check("lw_wait_cycles", 32'(r_cycles), 32'd8);
        check("lw_wait_dmreq", 32'(r_dmr), 32'd4);
        check("lw_wait_dmwe", 32'(r_dmw), 32'd0);
        check("lw_wait_wb", 32'(trace[7]), 32'd4);
        check("lw_wait_grf", 32'(r_grf), 32'd1);
        check("lw_wait_cnt", instr_cnt, 32'(exp_cnt));

        // sw ready exactly on the timeout cycle takes the normal exit
        run_instr(6'h2B, 6'h00, 1'b0, 14);
        exp_cnt++;
        check("sw_edge_mem", 32'(r_mem), 32'd15);
        check("sw_edge_cycles", 32'(r_cycles), 32'd18);
        check("sw_edge_err", {31'd0, err}, 32'd0);
        check("sw_edge_cnt", instr_cnt, 32'(exp_cnt));

        // sw never ready: ERR after 15 MEM cycles, then held
        run_instr(6'h2B, 6'h00, 1'b0, -1);
        check("sw_to_seen", 32'(r_saw_err), 32'd1);
        check("sw_to_mem", 32'(r_mem), 32'd15);
        check("sw_to_err", {31'd0, err}, 32'd1);
        check("sw_to_cnt", instr_cnt, 32'(exp_cnt));
        begin
            int hold_bad;
            hold_bad = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                dm_ready = c[0];
                #1;
                if (state != 3'd7 || err != 1'b1 ||
                    {ir_we, pc_we, grf_we, dm_req, dm_we} != 5'd0) hold_bad++;
            end
            check("err_hold", 32'(hold_bad), 32'd0);
        end

        // Async reset out of ERR
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        check("err_rst_state", 32'(state), 32'd0);
        check("err_rst_flags", {29'd0, err, ir_we, pc_we}, 32'd0);
        check("err_rst_cnt", instr_cnt, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Reset in the middle of an lw MEM wait
        opcode = 6'h23; func = 6'h00; dm_ready = 1'b0;
        begin
            int guard;
            guard = 0;
            while (state != 3'd3 && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
            check("mid_reach_mem", 32'(state), 32'd3);
        end
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_outs", {26'd0, ir_we, pc_we, grf_we, dm_req, dm_we, err}, 32'd0);
        check("mid_rst_npc", 32'(npc_sel), 32'd0);
        check("mid_rst_cnt", instr_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have one parameter: DM_TIMEOUT, default 15, the maximum number of MEM-state cycles spent waiting for dm_ready.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; every register SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port opcode, input, 6 bits: instruction-register bits [31:26].
REQ-005 The block SHALL have port func, input, 6 bits: instruction-register bits [5:0].
REQ-006 The block SHALL have port cmp_eq, input, 1 bit: equality flag from the comparator, valid in EXEC.
REQ-007 The block SHALL have port dm_ready, input, 1 bit: data-memory completion strobe.
REQ-008 The block SHALL have port ir_we, output, 1 bit: instruction-register load enable.
REQ-009 The block SHALL have port pc_we, output, 1 bit: PC load enable.
REQ-010 The block SHALL have port npc_sel, output, 2 bits: next-PC source; 0=PC+4, 1=branch, 2=imm26, 3=register.
REQ-011 The block SHALL have port grf_we, output, 1 bit: register-file write enable.
REQ-012 The block SHALL have port dm_req, output, 1 bit: data-memory access request.
REQ-013 The block SHALL have port dm_we, output, 1 bit: data-memory write qualifier for dm_req.
REQ-014 The block SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-015 The block SHALL have port instr_cnt, output, 32 bits: count of retired instructions.
REQ-016 The block SHALL have port err, output, 1 bit: sticky error flag.

Function
REQ-017 The FSM states SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=7.
REQ-018 Instruction classes SHALL be decoded as follows:
 - RTYPE: opcode 000000 with func 100001 or 100011
 - JR: opcode 000000 with func 001000
 - ORI: 001101; LUI: 001111; LW: 100011; SW: 101011; BEQ: 000100; JAL: 000011
 - every other encoding: NOP
REQ-019 In FETCH the block SHALL assert ir_we=1, pc_we=1 and npc_sel=0 for exactly one cycle, then go to DECODE.
REQ-020 DECODE SHALL last one cycle, with no enables asserted; a NOP retires here and the next state is FETCH, otherwise the next state is EXEC.
REQ-021 EXEC transitions SHALL be:
 - RTYPE, ORI, LUI -> WB
 - LW, SW -> MEM
 - BEQ, JR -> FETCH (retire)
 - JAL -> WB
REQ-022 In EXEC, BEQ with cmp_eq=1 SHALL assert pc_we with npc_sel=1; BEQ with cmp_eq=0 SHALL assert no pc_we; JR SHALL assert pc_we with npc_sel=3.
REQ-023 In WB the block SHALL assert grf_we for one cycle; for JAL it SHALL also assert pc_we with npc_sel=2; WB then goes to FETCH (retire).
REQ-024 In MEM, dm_req SHALL be 1 every cycle, with dm_we=1 for SW and 0 for LW.
REQ-025 MEM SHALL exit on the cycle dm_ready=1 is sampled: LW -> WB; SW -> FETCH (retire).
REQ-026 A MEM-wait counter SHALL clear on MEM entry and increment on each MEM cycle with dm_ready=0.
REQ-027 When the MEM-wait counter reaches DM_TIMEOUT with dm_ready=0, the next state SHALL be ERR.
REQ-028 When dm_ready=1 on the same cycle the counter reaches DM_TIMEOUT, the block SHALL take the normal MEM exit, not ERR.
REQ-029 In ERR all enables and dm_req SHALL be 0, err SHALL be 1, and the state SHALL be held until reset.
REQ-030 Cycles per instruction SHALL be:
 - NOP 2; BEQ and JR 3; RTYPE, ORI, LUI, JAL 4
 - SW 4+w; LW 5+w, where w is the number of dm_ready=0 MEM cycles
REQ-031 instr_cnt SHALL increment by 1 on each retire edge and SHALL wrap from 0xFFFFFFFF to 0.
REQ-032 dm_ready outside MEM SHALL be ignored.
REQ-033 Enables (ir_we, pc_we, grf_we, dm_req, dm_we) SHALL be a combinational function of state and the inputs; state and counters SHALL be registered.

Reset
REQ-034 When reset=0 the block SHALL asynchronously force state=FETCH, instr_cnt=0, err=0 and MEM-wait counter=0.
REQ-035 While reset=0 all enables and dm_req SHALL be 0, even though the state is FETCH.
REQ-036 Reset asserted mid-instruction, including during MEM wait or ERR, SHALL abort the instruction without incrementing instr_cnt.
REQ-037 After reset deasserts, the first rising edge SHALL perform the FETCH actions of REQ-019.

Verification
REQ-038 addu (op 0, func 0x21): the bench SHALL observe states 0,1,2,4,0 over 4 cycles, grf_we high only in WB, and instr_cnt 0->1.
REQ-039 beq with cmp_eq=1, then cmp_eq=0: the bench SHALL observe pc_we=1 with npc_sel=1 in EXEC for the first, no EXEC pc_we for the second, and 3 cycles each.
REQ-040 lw with dm_ready held 0 for 3 MEM cycles, then 1: the bench SHALL observe dm_req=1 and dm_we=0 for 4 cycles, then WB with grf_we=1, and 8 cycles total.
REQ-041 sw with dm_ready never asserted and DM_TIMEOUT=15: the bench SHALL observe ERR entered after 15 MEM cycles, err=1, all enables 0, and ERR persisting 20 more cycles.
REQ-042 Reset asserted in MEM mid-wait: the bench SHALL observe state=0, all outputs 0 and instr_cnt unchanged at 0, without waiting for a clock edge.
REQ-043 jal, then opcode 0x3F: the bench SHALL observe grf_we=1 and npc_sel=2 in WB for jal, and the 0x3F instruction retiring after DECODE in 2 cycles with instr_cnt incremented.
